imem_writer: RTL

Sequential instruction encoder and loader for the single-cycle CPU. It accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit ISA words. It writes the words to consecutive instruction-memory addresses starting at 0. It produces the words the processor's opcode decoder consumes, and is used by test harnesses and boot logic to fill imem before releasing the CPU from reset.

---
 rtl/isa_pkg.sv | 36 +++
 rtl/instr_encoder.sv | 36 +++
 rtl/imem_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode constants, instruction field positions and
// the loader session state encodings.
package isa_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    // LSB position of each field in the 32-bit instruction word
    localparam int POS_OP    = 27;
    localparam int POS_RD    = 22;
    localparam int POS_RS    = 17;
    localparam int POS_RT    = 12;
    localparam int POS_SHAMT = 7;
    localparam int POS_ALUOP = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Session ending scheduled by the word currently being written
    typedef enum logic [1:0] {
        FIN_NONE = 2'd0,
        FIN_DONE = 2'd1,
        FIN_ERR  = 2'd2
    } fin_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer: decoded instruction fields to a 32-bit ISA word plus
// a flag telling whether the opcode is one the CPU supports.
module instr_encoder
    import isa_pkg::*;
(
    input  logic [4:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  shamt_i,
    input  logic [4:0]  aluop_i,
    input  logic [16:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = is_legal_op(opcode_i);
        if (opcode_i == OP_R) begin
            word_o = (32'(opcode_i) << POS_OP)
                   | (32'(rd_i)     << POS_RD)
                   | (32'(rs_i)     << POS_RS)
                   | (32'(rt_i)     << POS_RT)
                   | (32'(shamt_i)  << POS_SHAMT)
                   | (32'(aluop_i)  << POS_ALUOP);
        end else if (legal_o) begin
            // I-type: for sw the rd slot carries the store-data register
            word_o = (32'(opcode_i) << POS_OP)
                   | (32'(rd_i)     << POS_RD)
                   | (32'(rs_i)     << POS_RS)
                   | 32'(imm_i);
        end
    end

endmodule

// File: rtl/imem_writer.sv
// Instruction-memory loader: accepts field bundles over valid/ready, encodes
// them and writes them to consecutive imem addresses starting at 0.
module imem_writer
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    state_e            state_q, state_d;
    fin_e              fin_q, fin_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   pend_inc;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        start_ok;

    instr_encoder u_enc (
        .opcode_i (in_opcode),
        .rd_i     (in_rd),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .shamt_i  (in_shamt),
        .aluop_i  (in_aluop),
        .imm_i    (in_imm),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state_q != RUN);
    assign pend_inc = pend_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (accept && !enc_legal)             state_d = ERR;
                else if (we_q && fin_q == FIN_DONE)   state_d = DONE;
                else if (we_q && fin_q == FIN_ERR)    state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Acceptance is closed once the session's final write is already scheduled
    always_comb begin
        in_ready = (state_q == RUN) && (pend_q < MAX_CNT) && (fin_q == FIN_NONE);
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        err      = (state_q == ERR);
    end

    always_comb begin
        we_d   = accept && enc_legal;
        addr_d = addr_q;
        data_d = data_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        fin_d  = fin_q;
        if (we_q) cnt_d = cnt_q + 1'b1;
        if (accept && enc_legal) begin
            addr_d = pend_q[ADDR_W-1:0];
            data_d = enc_word;
            pend_d = pend_inc;
            if (in_last)                  fin_d = FIN_DONE;
            else if (pend_inc == MAX_CNT) fin_d = FIN_ERR;
        end
        if (start_ok) begin
            pend_d = '0;
            cnt_d  = '0;
            fin_d  = FIN_NONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            fin_q  <= FIN_NONE;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            fin_q  <= fin_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign word_count = cnt_q;

endmodule
